integer_multiplier: RTL

INTEGER_MULTIPLIER -- requirements
Module: integer_multiplier

---
 rtl/integer_multiplier_if.sv | 23 ++
 rtl/integer_multiplier.sv | 85 ++++++++
 2 files changed

// File: rtl/integer_multiplier_if.sv
// Handshake and result bundle for the shift-add integer multiplier.
// The master drives the operands and go; the slave returns the result and status.
interface integer_multiplier_if #(
  parameter int W = 4
);
  logic           go;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           done;
  logic           busy;
  logic [2:0]     cs;

  modport master (
    output go, a, b,
    input  product, done, busy, cs
  );

  modport slave (
    input  go, a, b,
    output product, done, busy, cs
  );
endinterface

// File: rtl/integer_multiplier.sv
// Sequential shift-add unsigned multiplier: one TEST/[ADD]/SHIFT pass per
// multiplier bit, always running all W iterations.
module integer_multiplier #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  integer_multiplier_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplr_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  count_q;
  logic [2*W-1:0] product_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Unused codes 6 and 7 fall through to the default and return to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:  state_d = bus.go ? LOAD : IDLE;
      LOAD:  state_d = TEST;
      TEST:  state_d = mplr_q[0] ? ADD : SHIFT;
      ADD:   state_d = SHIFT;
      SHIFT: state_d = (count_q == CW'(1)) ? DONE : TEST;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are latched only on the edge leaving IDLE, so later changes on
  // a and b cannot disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.go) begin
            mcand_q <= {{W{1'b0}}, bus.a};
            mplr_q  <= bus.b;
            acc_q   <= '0;
            count_q <= CW'(W);
          end
        end
        ADD: acc_q <= acc_q + mcand_q;
        SHIFT: begin
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          count_q <= count_q - CW'(1);
        end
        DONE: product_q <= acc_q;
        default: ;
      endcase
    end
  end

  assign bus.cs      = state_q;
  assign bus.done    = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.product = product_q;

endmodule
